// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle control unit for the accumulator CPU.
// Every instruction goes through FETCH, DECODE and then EXEC and/or MEM and WB.
// FETCH and MEM wait on the mem_ready handshake.
// The unit also drives PC/IR control, an illegal-opcode halt and a retired-instruction counter.
// Control outputs are decoded from the current state and the latched opcode.
// A few outputs also use the sampled inputs where the handshake requires it:
//   - IRWrite, PCWrite and retire depend on mem_ready in FETCH and MEM.
//   - PCWrite and PCSrc depend on a_zero for JMP in EXEC.
// Because the state register resets asynchronously, every output drops to 0
// as soon as rst_n goes low.
module controle_multiciclo #(
    parameter int OPCODE_W        = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int RETIRE_CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_W-1:0]     opcode,
    input  logic                    a_zero,
    input  logic                    mem_ready,
    output logic                    InstrReq,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    PCSrc,
    output logic                    Branch,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    MemtoReg,
    output logic                    ALUSrc,
    output logic [1:0]              ALUOp,
    output logic                    RegWrite,
    output logic                    RegSel,
    output logic                    illegal,
    output logic                    halted,
    output logic                    retire,
    output logic [RETIRE_CNT_W-1:0] retired_cnt,
    output logic [2:0]              state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_LDB = 3'd4;
    localparam logic [2:0] OP_STB = 3'd5;
    localparam logic [2:0] OP_LDC = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    state_t                  state_q, state_d;
    logic [OPCODE_W-1:0]     op_q, op_d;
    logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

    // Opcode classification, always taken from the latched opcode.
    logic       op_legal;
    logic [2:0] op_lo;
    logic       is_alu;
    logic       is_jmp;
    logic       is_load;
    logic       is_store;
    logic       uses_b;
    logic [1:0] alu_op_of;

    assign op_lo    = op_q[2:0];
    assign op_legal = ((op_q >> 3) == '0);
    assign is_alu   = op_legal && ((op_lo == OP_ADD) || (op_lo == OP_SUB) || (op_lo == OP_LDC));
    assign is_jmp   = op_legal && (op_lo == OP_JMP);
    assign is_load  = op_legal && ((op_lo == OP_LDA) || (op_lo == OP_LDB));
    assign is_store = op_legal && ((op_lo == OP_STA) || (op_lo == OP_STB));
    assign uses_b   = op_legal && ((op_lo == OP_LDB) || (op_lo == OP_STB));
    assign alu_op_of = (op_lo == OP_SUB) ? ALU_SUB :
                       (op_lo == OP_LDC) ? ALU_PASS : ALU_ADD;

    assign state_o     = state_q;
    assign retired_cnt = cnt_q;

    // Next-state and control-output decode for the current state.
    always_comb begin
        state_d  = state_q;
        InstrReq = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        RegWrite = 1'b0;
        RegSel   = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        retire   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                // The request stays up for the whole wait; IR and PC update only on the handshake.
                InstrReq = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (is_alu || is_jmp) begin
                    state_d = ST_EXEC;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    illegal = 1'b1;
                    if (HALT_ON_ILLEGAL) begin
                        state_d = ST_HALT;
                    end else begin
                        // The illegal opcode is retired as a NOP.
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_EXEC: begin
                ALUSrc = 1'b1;
                if (is_jmp) begin
                    // The branch is taken only when the accumulator is zero.
                    Branch = 1'b1;
                    if (a_zero) begin
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    ALUOp   = alu_op_of;
                    state_d = is_alu ? ST_WB : ST_FETCH;
                end
            end

            ST_MEM: begin
                // The address is computed as base + immediate.
                ALUSrc = 1'b1;
                ALUOp  = ALU_ADD;
                RegSel = uses_b;
                if (is_store) begin
                    MemWrite = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                RegWrite = 1'b1;
                if (is_load) begin
                    MemtoReg = 1'b1;
                    RegSel   = uses_b;
                end else begin
                    // ALU operands stay stable so the written result does not glitch.
                    ALUSrc = 1'b1;
                    ALUOp  = alu_op_of;
                end
                retire  = 1'b1;
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                halted  = 1'b1;
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The opcode is captured only on the fetch handshake.
    always_comb begin
        op_d = op_q;
        if ((state_q == ST_FETCH) && mem_ready) begin
            op_d = opcode;
        end
    end

    // The retired-instruction counter wraps naturally at its width.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, latched opcode and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Testbench for controle_multiciclo.
// The stimulus queues the expected per-cycle control vector.
// A negedge monitor pops each queued vector and compares it with the outputs.
// Two instances share the same inputs:
//   - u_dut0 uses the default parameters (halt on illegal opcode, 16-bit counter).
//   - u_dut1 retires illegal opcodes as NOPs and has a 2-bit counter.
module tb_controle_multiciclo;

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq, irw, pcw, pcs, br, mr, mw, m2r, asrc;
        logic [1:0]  aop;
        logic        rw, rs, ill, hlt, ret;
        logic [15:0] cnt;
    } vec_t;

    localparam int C_IREQ = 1;
    localparam int C_IRW  = 2;
    localparam int C_PCW  = 4;
    localparam int C_PCS  = 8;
    localparam int C_BR   = 16;
    localparam int C_MR   = 32;
    localparam int C_MW   = 64;
    localparam int C_M2R  = 128;
    localparam int C_ASRC = 256;
    localparam int C_AOP0 = 512;
    localparam int C_AOP1 = 1024;
    localparam int C_RW   = 2048;
    localparam int C_RS   = 4096;
    localparam int C_ILL  = 8192;
    localparam int C_HLT  = 16384;
    localparam int C_RET  = 32768;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       a_zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       ireq0, irw0, pcw0, pcs0, br0, mr0, mw0, m2r0, asrc0, rw0, rs0, ill0, hlt0, ret0;
    logic [1:0] aop0;
    logic [15:0] cnt0;
    logic [2:0] st0;
    logic       ireq1, irw1, pcw1, pcs1, br1, mr1, mw1, m2r1, asrc1, rw1, rs1, ill1, hlt1, ret1;
    logic [1:0] aop1;
    logic [1:0] cnt1;
    logic [2:0] st1;

    vec_t v0, v1;
    assign v0 = {st0, ireq0, irw0, pcw0, pcs0, br0, mr0, mw0, m2r0, asrc0, aop0, rw0, rs0, ill0, hlt0, ret0, cnt0};
    assign v1 = {st1, ireq1, irw1, pcw1, pcs1, br1, mr1, mw1, m2r1, asrc1, aop1, rw1, rs1, ill1, hlt1, ret1, {14'd0, cnt1}};

    controle_multiciclo u_dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .a_zero(a_zero), .mem_ready(mem_ready),
        .InstrReq(ireq0), .IRWrite(irw0), .PCWrite(pcw0), .PCSrc(pcs0), .Branch(br0),
        .MemRead(mr0), .MemWrite(mw0), .MemtoReg(m2r0), .ALUSrc(asrc0), .ALUOp(aop0),
        .RegWrite(rw0), .RegSel(rs0), .illegal(ill0), .halted(hlt0), .retire(ret0),
        .retired_cnt(cnt0), .state_o(st0)
    );

    controle_multiciclo #(.OPCODE_W(4), .HALT_ON_ILLEGAL(1'b0), .RETIRE_CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .a_zero(a_zero), .mem_ready(mem_ready),
        .InstrReq(ireq1), .IRWrite(irw1), .PCWrite(pcw1), .PCSrc(pcs1), .Branch(br1),
        .MemRead(mr1), .MemWrite(mw1), .MemtoReg(m2r1), .ALUSrc(asrc1), .ALUOp(aop1),
        .RegWrite(rw1), .RegSel(rs1), .illegal(ill1), .halted(hlt1), .retire(ret1),
        .retired_cnt(cnt1), .state_o(st1)
    );

    always #5 clk = ~clk;

    vec_t  exp_q[$];
    int    dut_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    vec_t  m_exp;
    vec_t  m_act;
    int    m_dut;
    string m_name;

    // Monitor: compares one queued expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_exp  = exp_q.pop_front();
            m_dut  = dut_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = (m_dut == 0) ? v0 : v1;
            checks = checks + 1;
            if (m_act !== m_exp) begin
                errors = errors + 1;
                $display("FAIL %s dut%0d: got %h expected %h", m_name, m_dut, m_act, m_exp);
            end else begin
                $display("ok   %s dut%0d: st=%0d cnt=%0d", m_name, m_dut, m_act.st, m_act.cnt);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic step(input string nm, input int d, input logic mr, input logic az,
                        input logic [3:0] op, input logic [2:0] st, input int ctrl,
                        input logic [15:0] cnt);
        logic [15:0] c;
        vec_t e;
        c = ctrl[15:0];
        mem_ready = mr;
        a_zero    = az;
        opcode    = op;
        e.st   = st;
        e.ireq = c[0];  e.irw = c[1];  e.pcw = c[2];  e.pcs = c[3];
        e.br   = c[4];  e.mr  = c[5];  e.mw  = c[6];  e.m2r = c[7];
        e.asrc = c[8];  e.aop = {c[10], c[9]};
        e.rw   = c[11]; e.rs  = c[12]; e.ill = c[13]; e.hlt = c[14]; e.ret = c[15];
        e.cnt  = cnt;
        exp_q.push_back(e);
        dut_q.push_back(d);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int d, input logic [3:0] op, input logic [15:0] cnt);
        step("fetch", d, 1'b1, 1'b0, op, 3'd1, C_IREQ | C_IRW | C_PCW, cnt);
    endtask

    task automatic decode(input int d, input logic [15:0] cnt);
        step("decode", d, 1'b1, 1'b1, 4'hA, 3'd2, 0, cnt);
    endtask

    task automatic alu(input string nm, input int d, input logic [3:0] op, input int aopc,
                       input logic [15:0] cnt);
        fetch(d, op, cnt);
        decode(d, cnt);
        step({nm, "_exec"}, d, 1'b0, 1'b0, 4'h9, 3'd3, C_ASRC | aopc, cnt);
        step({nm, "_wb"}, d, 1'b0, 1'b0, 4'h9, 3'd5, C_RW | C_ASRC | aopc | C_RET, cnt);
    endtask

    task automatic store(input string nm, input int d, input logic [3:0] op, input int rs,
                         input logic [15:0] cnt);
        fetch(d, op, cnt);
        decode(d, cnt);
        step({nm, "_mem"}, d, 1'b1, 1'b0, 4'hF, 3'd4, C_MW | C_ASRC | rs | C_RET, cnt);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset and release on the default-parameter instance.
        step("reset", 0, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);
        step("reset", 0, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);
        rst_n = 1'b1;
        step("idle", 0, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);

        alu("add", 0, 4'h0, 0, 16'd0);
        alu("sub", 0, 4'h1, C_AOP0, 16'd1);
        alu("ldc", 0, 4'h6, C_AOP1, 16'd2);

        // LDB with one fetch wait cycle and three memory wait cycles.
        step("fetch_wait", 0, 1'b0, 1'b0, 4'h2, 3'd1, C_IREQ, 16'd3);
        fetch(0, 4'h4, 16'd3);
        decode(0, 16'd3);
        for (int i = 0; i < 3; i++)
            step("ldb_mem_wait", 0, 1'b0, 1'b0, 4'h3, 3'd4, C_MR | C_ASRC | C_RS, 16'd3);
        step("ldb_mem", 0, 1'b1, 1'b0, 4'h3, 3'd4, C_MR | C_ASRC | C_RS, 16'd3);
        step("ldb_wb", 0, 1'b0, 1'b0, 4'h3, 3'd5, C_RW | C_M2R | C_RS | C_RET, 16'd3);

        store("stb", 0, 4'h5, C_RS, 16'd4);

        // JMP taken and not taken.
        fetch(0, 4'h7, 16'd5);
        decode(0, 16'd5);
        step("jmp_taken", 0, 1'b0, 1'b1, 4'h0, 3'd3, C_BR | C_ASRC | C_PCW | C_PCS | C_RET, 16'd5);
        fetch(0, 4'h7, 16'd6);
        step("decode", 0, 1'b1, 1'b1, 4'h0, 3'd2, 0, 16'd6);
        step("jmp_not_taken", 0, 1'b1, 1'b0, 4'h0, 3'd3, C_BR | C_ASRC | C_RET, 16'd6);

        // LDA and STA with zero-wait memory.
        fetch(0, 4'h2, 16'd7);
        decode(0, 16'd7);
        step("lda_mem", 0, 1'b1, 1'b0, 4'h0, 3'd4, C_MR | C_ASRC, 16'd7);
        step("lda_wb", 0, 1'b1, 1'b0, 4'h0, 3'd5, C_RW | C_M2R | C_RET, 16'd7);
        store("sta", 0, 4'h3, 0, 16'd8);

        // Illegal opcode halts; mem_ready activity is ignored in HALT.
        fetch(0, 4'hF, 16'd9);
        step("illegal_decode", 0, 1'b1, 1'b0, 4'h0, 3'd2, C_ILL, 16'd9);
        step("halt", 0, 1'b1, 1'b0, 4'h0, 3'd6, C_HLT, 16'd9);
        step("halt", 0, 1'b0, 1'b0, 4'h1, 3'd6, C_HLT, 16'd9);
        step("halt", 0, 1'b1, 1'b1, 4'h2, 3'd6, C_HLT, 16'd9);
        rst_n = 1'b0;
        step("halt_reset", 0, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);

        // Second instance: counter wrap, illegal-as-NOP, reset during MEM.
        step("reset", 1, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);
        rst_n = 1'b1;
        step("idle", 1, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);
        store("sta1", 1, 4'h3, 0, 16'd0);
        store("sta2", 1, 4'h3, 0, 16'd1);
        store("sta3", 1, 4'h3, 0, 16'd2);
        store("sta4", 1, 4'h3, 0, 16'd3);
        store("sta5", 1, 4'h3, 0, 16'd0);
        fetch(1, 4'hF, 16'd1);
        step("illegal_nop", 1, 1'b1, 1'b0, 4'h0, 3'd2, C_ILL | C_RET, 16'd1);
        fetch(1, 4'h3, 16'd2);
        decode(1, 16'd2);
        step("sta_mem_wait", 1, 1'b0, 1'b0, 4'h0, 3'd4, C_MW | C_ASRC, 16'd2);
        rst_n = 1'b0;
        step("mem_reset", 1, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);
        step("mem_reset", 1, 1'b1, 1'b0, 4'h0, 3'd0, 0, 16'd0);

        repeat (2) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multi-cycle control unit for the accumulator CPU, replacing the single-cycle combinational decoder. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a memory ready handshake. It drives the same datapath control signals, plus PC/IR control, an illegal-opcode halt and a retired-instruction counter. It sits between instruction/data memory and the PC, IR, ALU and register A/B datapath.

## Interface
- OPCODE_W, 4, opcode width (≥4); any opcode with a nonzero bit above bit 3 is illegal
- HALT_ON_ILLEGAL, 1, 1: illegal opcode enters HALT; 0: illegal opcode is retired as a NOP
- RETIRE_CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  OPCODE_W  instruction-memory opcode field, sampled on the FETCH handshake
- a_zero  in  1  accumulator A == 0, sampled in EXEC for JMP
- mem_ready  in  1  memory has completed the current request
- InstrReq  out  1  instruction fetch request
- IRWrite  out  1  load the IR
- PCWrite  out  1  update the PC
- PCSrc  out  1  0: PC+1; 1: branch target (imm)
- Branch  out  1  JMP executing
- MemRead  out  1  data memory read
- MemWrite  out  1  data memory write
- MemtoReg  out  1  write-back data comes from memory
- ALUSrc  out  1  ALU operand B = immediate
- ALUOp  out  2  00 add, 01 sub, 10 pass-B
- RegWrite  out  1  register write
- RegSel  out  1  target/source register: 0 = A, 1 = B
- illegal  out  1  one-cycle pulse when an illegal opcode is decoded
- halted  out  1  unit is in HALT
- retire  out  1  one-cycle pulse when an instruction completes
- retired_cnt  out  RETIRE_CNT_W  number of instructions completed
- state_o  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6

## Operation
- Opcode map: ADD=0, SUB=1, LDA=2, STA=3, LDB=4, STB=5, LDC=6, JMP=7. Opcodes 8–15 and any value with upper bits set are illegal.
- Opcode is latched into op_q on the FETCH cycle where mem_ready=1. DECODE and later states use only op_q.
- Outputs are Moore-style, decoded from state and op_q. Any signal not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: InstrReq=1. While mem_ready=0, stay in FETCH. When mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, next state DECODE.
- DECODE: no control outputs asserted.
  - ADD, SUB, LDC, JMP → EXEC.
  - LDA, LDB, STA, STB → MEM.
  - Illegal opcode: illegal=1. Next state HALT if HALT_ON_ILLEGAL=1; otherwise FETCH with retire=1.
- EXEC:
  - ADD: ALUSrc=1, ALUOp=00, next state WB.
  - SUB: ALUSrc=1, ALUOp=01, next state WB.
  - LDC: ALUSrc=1, ALUOp=10, next state WB.
  - JMP: Branch=1, ALUSrc=1. If a_zero=1 then also PCWrite=1 and PCSrc=1. Next state FETCH, retire=1.
- MEM: ALUSrc=1, ALUOp=00. RegSel=1 for LDB and STB, 0 otherwise.
  - Loads: MemRead=1. Hold in MEM until mem_ready=1, then go to WB.
  - Stores: MemWrite=1. Hold in MEM until mem_ready=1, then go to FETCH with retire=1.
- WB: RegWrite=1. MemtoReg=1 for LDA/LDB. RegSel=1 for LDB. ALUSrc and ALUOp are held at their EXEC values for ALU ops. Next state FETCH, retire=1.
- HALT: all control outputs 0, halted=1. HALT is left only by reset.
- retired_cnt increments by 1 on every retire and wraps from 2^RETIRE_CNT_W−1 to 0.
- mem_ready is ignored outside FETCH and MEM.

## Timing
- Reset state (asynchronous, while rst_n=0 and immediately on its assertion):
  - state=IDLE, op_q=0, retired_cnt=0, halted=0.
  - All control outputs, illegal and retire are 0.
- First FETCH occurs in the first cycle after the first clk edge following reset release.
- Cycle counts with mem_ready held at 1, measured FETCH to the next FETCH:
  - ADD/SUB/LDC: 4 cycles.
  - LDA/LDB: 4 cycles.
  - STA/STB: 3 cycles.
  - JMP: 3 cycles.
  - Illegal with HALT_ON_ILLEGAL=0: 2 cycles.
- Each cycle with mem_ready=0 in FETCH or MEM adds one cycle. The request signal (InstrReq, MemRead or MemWrite) stays asserted and stable throughout the wait.
- retire is asserted in the last cycle of the instruction. retired_cnt shows the new value in the cycle after retire.
- Reset asserted mid-instruction aborts it: outputs drop to 0 asynchronously, no retire is issued, and the counter clears.
- The opcode input may change freely outside the FETCH handshake cycle without effect.

## Test plan
- Reset release with mem_ready=1 → state_o sequence 0,1; outputs all 0 during reset and in IDLE.
- Opcodes ADD, SUB, LDC with zero-wait memory → DECODE,EXEC,WB:
  - ALUOp is 00, 01, 10 respectively.
  - RegWrite=1 only in WB.
  - retire pulses; retired_cnt goes 0→1→2→3.
- LDB with mem_ready held low 3 cycles in MEM → MemRead=1 and RegSel=1 held for 4 cycles, then WB with MemtoReg=1, RegSel=1. STB → MemWrite=1 for 1 cycle, then FETCH.
- JMP with a_zero=1 → PCWrite=1, PCSrc=1 in EXEC. JMP with a_zero=0 → Branch=1, PCWrite=0.
- Opcode 4'hF with HALT_ON_ILLEGAL=1 → illegal pulse, state 6, halted=1 held despite mem_ready toggling, until rst_n low. Same opcode with HALT_ON_ILLEGAL=0 → retire pulse, back to FETCH.
- RETIRE_CNT_W=2 with 5 STA instructions → retired_cnt reads 1,2,3,0,1. Reset asserted during MEM → counter reads 0, no retire pulse.
